// File: rtl/inst_issue.sv
// inst_issue: transmitter at the head of the 32-bit instruction daisy-chain.
// Takes one command (unit id, word count, run flag, priority), pulls 16-bit
// payload beats and turns each one into a load word with an incrementing
// address. It can then append a run word. Words leave on a valid/ready stream.
//
// Handshake rule on every port: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// data stable until that edge. inst_s_valid never drops without a transfer.

module inst_issue #(
    parameter int          IW       = 32,
    parameter int          MAX_CNT  = 16,
    parameter logic [3:0]  RUN_ADDR = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    cmd_m_id,
    input  logic [4:0]    cmd_m_cnt,
    input  logic          cmd_m_run,
    input  logic [1:0]    cmd_m_prior,
    input  logic          cmd_m_valid,
    output logic          cmd_m_ready,
    input  logic [15:0]   pld_m_data,
    input  logic          pld_m_valid,
    output logic          pld_m_ready,
    output logic [IW-1:0] inst_s_data,
    output logic          inst_s_valid,
    input  logic          inst_s_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  id_q;
    logic [4:0]  cnt_q;
    logic        run_q;
    logic [1:0]  prior_q;
    logic [3:0]  idx_q;

    logic        out_free;
    logic        cmd_fire;
    logic        pld_fire;
    logic        last_beat;
    logic [4:0]  cnt_clamped;
    logic [IW-1:0] load_word;
    logic [IW-1:0] run_word;

    // The output register can take a new word when it is empty or its word leaves this cycle
    assign out_free    = !inst_s_valid || inst_s_ready;

    // cmd_m_ready is gated by rst_n so that no command is accepted while reset is held
    assign cmd_m_ready = (state == IDLE) && rst_n;
    assign pld_m_ready = (state == LOAD) && out_free;
    assign busy        = (state != IDLE);

    assign cmd_fire    = cmd_m_valid && cmd_m_ready;
    assign pld_fire    = pld_m_valid && pld_m_ready;

    assign cnt_clamped = (cmd_m_cnt > 5'(MAX_CNT)) ? 5'(MAX_CNT) : cmd_m_cnt;

    // The beat with index cnt-1 is the last load. idx_q is 4 bits, so a count of 16 uses addresses 0..15
    assign last_beat   = ({1'b0, idx_q} == (cnt_q - 5'd1));

    // Word layout, MSB first: run, id, addr, prior, 6 reserved zero bits, data
    assign load_word   = IW'({1'b0, id_q, idx_q, prior_q, 6'b0, pld_m_data});
    assign run_word    = IW'({1'b1, id_q, RUN_ADDR, prior_q, 6'b0, 16'h0000});

    // Command FSM together with the output register, latched fields and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            id_q         <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            prior_q      <= '0;
            idx_q        <= '0;
            inst_s_data  <= '0;
            inst_s_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            // Once the held word leaves, valid drops. A branch below raises it again if it has a new word
            if (inst_s_valid && inst_s_ready) begin
                inst_s_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        id_q    <= cmd_m_id;
                        cnt_q   <= cnt_clamped;
                        run_q   <= cmd_m_run;
                        prior_q <= cmd_m_prior;
                        idx_q   <= '0;
                        if (cnt_clamped != 5'd0) begin
                            state <= LOAD;
                        end else if (cmd_m_run) begin
                            state <= RUN;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                LOAD: begin
                    if (pld_fire) begin
                        inst_s_data  <= load_word;
                        inst_s_valid <= 1'b1;
                        idx_q        <= idx_q + 4'd1;
                        if (last_beat) begin
                            state <= run_q ? RUN : WAIT;
                        end
                    end
                end
                RUN: begin
                    if (out_free) begin
                        inst_s_data  <= run_word;
                        inst_s_valid <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // Finish only after the last word has been taken, so done marks full completion
                    if (out_free) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
